// File: rtl/axi_aw_rr_scheduler.sv
// AW channel round-robin scheduler for one initiator port.
// Holds the winning AW stable until accepted and limits outstanding writes.
module axi_aw_rr_scheduler #(
  parameter int N_TARG_PORT     = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int AUX_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 8,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_TARG_PORT-1:0]                 req_valid_i,
  input  logic [N_TARG_PORT-1:0][ADDR_WIDTH-1:0] req_addr_i,
  input  logic [N_TARG_PORT-1:0][AUX_WIDTH-1:0]  req_aux_i,
  output logic [N_TARG_PORT-1:0]                 req_ready_o,
  output logic                                   awvalid_o,
  output logic [ADDR_WIDTH-1:0]                  awaddr_o,
  output logic [AUX_WIDTH-1:0]                   awaux_o,
  input  logic                                   awready_i,
  input  logic                                   fifo_grant_i,
  output logic [N_TARG_PORT-1:0]                 route_o,
  output logic                                   route_push_o,
  input  logic                                   b_done_i,
  output logic [CNT_W-1:0]                       outstanding_o,
  output logic                                   full_o,
  output logic                                   underflow_o
);

  localparam int PTR_W = (N_TARG_PORT > 1) ? $clog2(N_TARG_PORT) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N_TARG_PORT - 1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [AUX_WIDTH-1:0]    aux_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    unf_q;

  logic [PTR_W-1:0]        win_idx;
  logic [PTR_W:0]          scan;
  logic                    found;
  logic                    can_accept;
  logic                    accept;
  logic                    dec;
  logic [N_TARG_PORT-1:0]  grant_oh;

  // Accept gating: FIFO space, credit (or a returning one), free slot
  always_comb begin
    can_accept = fifo_grant_i
               & ((cnt_q < MAX_CNT) | b_done_i)
               & ((state_q == IDLE) | awready_i);
    accept     = can_accept & (|req_valid_i);
    dec        = b_done_i & (cnt_q != '0);
  end

  // Round-robin scan starting just above the last grant
  always_comb begin
    win_idx = ptr_q;
    found   = 1'b0;
    scan    = '0;
    for (int i = 1; i <= N_TARG_PORT; i++) begin
      scan = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (scan >= (PTR_W+1)'(N_TARG_PORT))
        scan = scan - (PTR_W+1)'(N_TARG_PORT);
      if (!found && req_valid_i[scan[PTR_W-1:0]]) begin
        found   = 1'b1;
        win_idx = scan[PTR_W-1:0];
      end
    end
    grant_oh = '0;
    if (accept)
      grant_oh[win_idx] = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: a new acceptance always lands in HOLD
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = HOLD;
      HOLD: begin
        if (accept)         state_d = HOLD;
        else if (awready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    awvalid_o     = (state_q == HOLD);
    awaddr_o      = addr_q;
    awaux_o       = aux_q;
    req_ready_o   = grant_oh;
    route_o       = grant_oh;
    route_push_o  = accept;
    outstanding_o = cnt_q;
    full_o        = (cnt_q == MAX_CNT);
    underflow_o   = unf_q;
  end

  // Holding register and arbitration pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= LAST;
      addr_q <= '0;
      aux_q  <= '0;
    end else if (accept) begin
      ptr_q  <= win_idx;
      addr_q <= req_addr_i[win_idx];
      aux_q  <= req_aux_i[win_idx];
    end
  end

  // Outstanding counter and sticky underflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      unf_q <= 1'b0;
    end else begin
      if (accept && !dec)      cnt_q <= cnt_q + CNT_W'(1);
      else if (!accept && dec) cnt_q <= cnt_q - CNT_W'(1);
      if (b_done_i && cnt_q == '0)
        unf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_aw_rr_scheduler.sv
// Directed bench for the AW round-robin scheduler.
// Inputs change 1ns after posedge; checks run 1ns later.
module tb_axi_aw_rr_scheduler;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        req_valid;
  logic [3:0][31:0]  req_addr;
  logic [3:0][15:0]  req_aux;
  logic [3:0]        req_ready;
  logic              awvalid;
  logic [31:0]       awaddr;
  logic [15:0]       awaux;
  logic              awready;
  logic              fifo_grant;
  logic [3:0]        route;
  logic              route_push;
  logic              b_done;
  logic [3:0]        outstanding;
  logic              full;
  logic              underflow;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_aw_rr_scheduler #(
    .N_TARG_PORT(4), .ADDR_WIDTH(32),
    .AUX_WIDTH(16), .MAX_OUTSTANDING(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_aux_i(req_aux), .req_ready_o(req_ready),
    .awvalid_o(awvalid), .awaddr_o(awaddr),
    .awaux_o(awaux), .awready_i(awready),
    .fifo_grant_i(fifo_grant), .route_o(route),
    .route_push_o(route_push), .b_done_i(b_done),
    .outstanding_o(outstanding), .full_o(full),
    .underflow_o(underflow)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next edge (input drive point)
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before checking
  task automatic settle();
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    awready    = 1'b0;
    fifo_grant = 1'b1;
    b_done     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 32'h2000_0000 + 32'(i * 16);
      req_aux[i]  = 16'h0100 + 16'(i);
    end
    cyc(); cyc();
    settle();
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_awaddr", 64'(awaddr), 64'd0);
    chk("rst_awaux", 64'(awaux), 64'd0);
    chk("rst_cnt", 64'(outstanding), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_unf", 64'(underflow), 64'd0);
    chk("rst_push", 64'(route_push), 64'd0);

    // Single request from port 2
    cyc();
    rst         = 1'b0;
    req_valid   = 4'b0100;
    req_addr[2] = 32'h1000_0040;
    req_aux[2]  = 16'h00A5;
    awready     = 1'b1;
    settle();
    chk("single_ready", 64'(req_ready), 64'h4);
    chk("single_push", 64'(route_push), 64'd1);
    chk("single_route", 64'(route), 64'h4);
    cyc();
    req_valid = '0;
    b_done    = 1'b1;
    settle();
    chk("single_awvalid", 64'(awvalid), 64'd1);
    chk("single_awaddr", 64'(awaddr), 64'h1000_0040);
    chk("single_awaux", 64'(awaux), 64'h00A5);
    chk("single_cnt", 64'(outstanding), 64'd1);
    chk("single_ready_off", 64'(req_ready), 64'd0);
    cyc();
    b_done = 1'b0;
    req_addr[2] = 32'h2000_0020;
    req_aux[2]  = 16'h0102;
    settle();
    chk("single_idle", 64'(awvalid), 64'd0);
    chk("single_drain", 64'(outstanding), 64'd0);

    // Fairness: pointer sits at 2, so order is 3,0,1,2,3,0
    req_valid = 4'b1111;
    begin
      int exp_w [6] = '{3, 0, 1, 2, 3, 0};
      for (int k = 0; k < 6; k++) begin
        settle();
        chk($sformatf("rr_ready%0d", k), 64'(req_ready),
            64'(4'b1 << exp_w[k]));
        chk($sformatf("rr_route%0d", k), 64'(route),
            64'(4'b1 << exp_w[k]));
        if (k > 0) begin
          chk($sformatf("rr_awaddr%0d", k), 64'(awaddr),
              64'(32'h2000_0000 + 32'(exp_w[k-1] * 16)));
          chk($sformatf("rr_awvalid%0d", k), 64'(awvalid), 64'd1);
        end
        cyc();
      end
    end
    req_valid = '0;
    settle();
    chk("rr_last_addr", 64'(awaddr), 64'h2000_0000);
    chk("rr_last_aux", 64'(awaux), 64'h0100);
    chk("rr_cnt", 64'(outstanding), 64'd6);
    cyc();
    b_done = 1'b1;
    repeat (6) cyc();
    b_done = 1'b0;
    settle();
    chk("rr_drain", 64'(outstanding), 64'd0);
    chk("rr_idle", 64'(awvalid), 64'd0);

    // Backpressure: pointer at 0, port 1 wins, held 5 cycles
    awready   = 1'b0;
    req_valid = 4'b0010;
    settle();
    chk("bp_ready1", 64'(req_ready), 64'h2);
    cyc();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        req_valid   = 4'b1000;
        req_addr[3] = 32'h3333_0000;
        req_aux[3]  = 16'h0333;
      end
      settle();
      chk($sformatf("bp_addr%0d", k), 64'(awaddr), 64'h2000_0010);
      chk($sformatf("bp_aux%0d", k), 64'(awaux), 64'h0101);
      chk($sformatf("bp_valid%0d", k), 64'(awvalid), 64'd1);
      chk($sformatf("bp_noready%0d", k), 64'(req_ready), 64'd0);
      cyc();
    end
    awready = 1'b1;
    settle();
    chk("bp_ready3", 64'(req_ready), 64'h8);
    chk("bp_push3", 64'(route_push), 64'd1);
    cyc();
    req_valid = '0;
    settle();
    chk("bp_addr3", 64'(awaddr), 64'h3333_0000);
    chk("bp_valid3", 64'(awvalid), 64'd1);
    chk("bp_cnt", 64'(outstanding), 64'd2);
    cyc();
    b_done = 1'b1;
    repeat (2) cyc();
    b_done = 1'b0;
    settle();
    chk("bp_drain", 64'(outstanding), 64'd0);

    // Outstanding limit: port 0 issues 8, then blocks
    req_valid = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk($sformatf("lim_ready%0d", k), 64'(req_ready), 64'h1);
      cyc();
    end
    settle();
    chk("lim_cnt", 64'(outstanding), 64'd8);
    chk("lim_full", 64'(full), 64'd1);
    chk("lim_block", 64'(req_ready), 64'd0);
    chk("lim_hold", 64'(awvalid), 64'd1);
    cyc();
    settle();
    chk("lim_done", 64'(awvalid), 64'd0);
    chk("lim_block2", 64'(req_ready), 64'd0);
    b_done = 1'b1;
    settle();
    chk("lim_bdone_ready", 64'(req_ready), 64'h1);
    cyc();
    b_done    = 1'b0;
    req_valid = '0;
    settle();
    chk("lim_cnt_same", 64'(outstanding), 64'd8);
    chk("lim_full2", 64'(full), 64'd1);
    cyc();
    b_done = 1'b1;
    repeat (8) cyc();
    b_done = 1'b0;
    settle();
    chk("lim_drain", 64'(outstanding), 64'd0);
    chk("lim_notfull", 64'(full), 64'd0);

    // FIFO backpressure blocks acceptance only
    fifo_grant = 1'b0;
    req_valid  = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("fifo_block%0d", k), 64'(req_ready), 64'd0);
      chk($sformatf("fifo_nopush%0d", k), 64'(route_push), 64'd0);
      cyc();
    end
    fifo_grant = 1'b1;
    settle();
    chk("fifo_grant", 64'(req_ready), 64'h1);
    cyc();
    req_valid = '0;
    settle();
    chk("fifo_cnt", 64'(outstanding), 64'd1);

    // Underflow: drain to 0, then one more b_done
    b_done = 1'b1;
    cyc();
    settle();
    chk("unf_pre_cnt", 64'(outstanding), 64'd0);
    chk("unf_pre", 64'(underflow), 64'd0);
    cyc();
    b_done = 1'b0;
    settle();
    chk("unf_set", 64'(underflow), 64'd1);
    chk("unf_cnt", 64'(outstanding), 64'd0);

    // Reset during HOLD; pointer at 0 so port 2 wins here
    awready   = 1'b0;
    req_valid = 4'b0100;
    settle();
    chk("rh_ready", 64'(req_ready), 64'h4);
    cyc();
    req_valid = '0;
    settle();
    chk("rh_hold", 64'(awvalid), 64'd1);
    rst = 1'b1;
    cyc();
    settle();
    chk("rh_awvalid", 64'(awvalid), 64'd0);
    chk("rh_unf", 64'(underflow), 64'd0);
    chk("rh_cnt", 64'(outstanding), 64'd0);
    chk("rh_addr", 64'(awaddr), 64'd0);
    cyc();
    rst       = 1'b0;
    awready   = 1'b1;
    req_valid = 4'b1111;
    settle();
    chk("rh_prio0", 64'(req_ready), 64'h1);
    cyc();
    req_valid = '0;
    settle();
    chk("rh_addr0", 64'(awaddr), 64'h2000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
